// File: rtl/fir_decimator.sv
// fir_decimator: block-averages the FIR output over 2^D samples into a small result FIFO,
// tracks per-window min/max and counts rising threshold crossings, on the TinyQV byte bus.
module fir_decimator #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_LOG2   = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [7:0] uo_out,
  output logic       user_interrupt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic        [4:0]          ctrl_q;
  logic signed [14:0]         acc_q, acc_d;
  logic        [MAX_LOG2-1:0] cnt_q, cnt_d;
  logic signed [7:0]          wmin_q, wmin_d, wmax_q, wmax_d;
  logic signed [7:0]          prev_q, thresh_q;
  logic                       prev_valid_q, ovf_q;
  logic        [7:0]          mem_q [FIFO_DEPTH];
  logic        [AW-1:0]       wp_q, rp_q;
  logic        [LW-1:0]       level_q;
  logic        [7:0]          max_q, min_q, xcnt_q, avg_q;

  logic              en, restart, take, last, push, pop, push_ok, empty, full, xing;
  logic        [2:0] d;
  logic signed [7:0] s, new_min, new_max;
  logic signed [14:0] sum;
  logic        [7:0] avg;

  assign en      = ctrl_q[0];
  assign d       = ctrl_q[3:1];
  assign s       = sample_in;
  // A CTRL write that changes EN or D throws away the partial window.
  assign restart = data_write && address == 4'h0 && data_in[3:0] != ctrl_q[3:0];
  assign take    = en && sample_valid && !restart;
  assign sum     = acc_q + 15'(s);
  assign avg     = 8'(sum >>> d);
  assign last    = cnt_q == MAX_LOG2'((32'd1 << d) - 32'd1);
  assign new_min = s < wmin_q ? s : wmin_q;
  assign new_max = s > wmax_q ? s : wmax_q;
  assign push    = take && last;
  assign empty   = level_q == '0;
  assign full    = level_q == LW'(FIFO_DEPTH);
  assign pop     = data_write && address == 4'h2 && !empty;
  assign push_ok = push && (!full || pop);
  assign xing    = en && sample_valid && prev_valid_q && prev_q < thresh_q && s >= thresh_q;

  assign uo_out         = avg_q;
  assign user_interrupt = ctrl_q[4] & ~empty;

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    wmin_d = wmin_q;
    wmax_d = wmax_q;
    if (!en || restart || push) begin
      acc_d  = '0;
      cnt_d  = '0;
      wmin_d = 8'h7F;
      wmax_d = 8'h80;
    end else if (take) begin
      acc_d  = sum;
      cnt_d  = cnt_q + MAX_LOG2'(1);
      wmin_d = new_min;
      wmax_d = new_max;
    end
  end

  always_comb begin
    data_out = '0;
    case (address)
      4'h0: data_out = {3'b0, ctrl_q};
      4'h1: data_out = {2'b0, 3'(level_q), ovf_q, full, empty};
      4'h2: data_out = empty ? 8'h00 : mem_q[rp_q];
      4'h3: data_out = max_q;
      4'h4: data_out = min_q;
      4'h5: data_out = thresh_q;
      4'h6: data_out = xcnt_q;
      default: data_out = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q       <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      wmin_q       <= 8'h7F;
      wmax_q       <= 8'h80;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      thresh_q     <= '0;
      ovf_q        <= 1'b0;
      wp_q         <= '0;
      rp_q         <= '0;
      level_q      <= '0;
      max_q        <= '0;
      min_q        <= '0;
      xcnt_q       <= '0;
      avg_q        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (data_write && address == 4'h0) ctrl_q <= data_in[4:0];
      if (data_write && address == 4'h5) thresh_q <= data_in;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      wmin_q <= wmin_d;
      wmax_q <= wmax_d;
      if (push) begin
        avg_q <= avg;
        max_q <= new_max;
        min_q <= new_min;
      end
      if (!en) prev_valid_q <= 1'b0;
      else if (sample_valid) begin
        prev_q       <= s;
        prev_valid_q <= 1'b1;
      end
      if (push_ok) begin
        mem_q[wp_q] <= avg;
        wp_q        <= wp_q + AW'(1);
      end
      if (pop) rp_q <= rp_q + AW'(1);
      level_q <= level_q + LW'(push_ok) - LW'(pop);
      if (push && full && !pop) ovf_q <= 1'b1;
      else if (data_write && address == 4'h1 && data_in[2]) ovf_q <= 1'b0;
      // Software clear beats a simultaneous crossing.
      if (data_write && address == 4'h6) xcnt_q <= '0;
      else if (xing && xcnt_q != 8'hFF) xcnt_q <= xcnt_q + 8'd1;
    end
  end
endmodule
